// File: rtl/spi_slave_if.sv
// SPI target endpoint: oversampled SCK/NSS/MOSI, rx deserializer with valid pulse, one-entry tx holding register.
// Optional build macro SPI_SLAVE_LSB_FIRST_EN selects LSB-first shifting (default MSB-first).
module spi_slave_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_nss_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_en_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  udr_o,
  output logic                  abort_o,
  input  logic                  flag_clr_i
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, nss_sync, mosi_sync;
  logic                   sck_d, nss_d;
  logic                   sck_s, nss_s, mosi_s;
  logic                   sck_rise, sck_fall, nss_rise, nss_fall;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;

  logic [DATA_WIDTH-1:0]  shift_tx, shift_rx, hold_data;
  logic [DATA_WIDTH-1:0]  rx_next, tx_shifted;
  logic                   tx_bit, hold_full, load_pending;
  logic [CW-1:0]          bit_cnt;
  logic                   last_bit;

  logic enter, do_load, do_shift, do_sample, do_abort, capture;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync  <= '0;
      nss_sync  <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      nss_d     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi_nss_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      nss_d     <= nss_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign nss_s    = nss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign nss_rise = nss_s & ~nss_d;
  assign nss_fall = ~nss_s & nss_d;

  assign lead_edge   = cpol_i ? sck_fall : sck_rise;
  assign trail_edge  = cpol_i ? sck_rise : sck_fall;
  assign sample_edge = cpha_i ? trail_edge : lead_edge;
  assign shift_edge  = cpha_i ? lead_edge : trail_edge;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next    = {mosi_s, shift_rx[DATA_WIDTH-1:1]};
  assign tx_shifted = {1'b0, shift_tx[DATA_WIDTH-1:1]};
  assign tx_bit     = shift_tx[0];
`else
  assign rx_next    = {shift_rx[DATA_WIDTH-2:0], mosi_s};
  assign tx_shifted = {shift_tx[DATA_WIDTH-2:0], 1'b0};
  assign tx_bit     = shift_tx[DATA_WIDTH-1];
`endif

  assign last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (nss_fall) state_next = ACTIVE;
      ACTIVE:  if (nss_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    busy_o    = 1'b0;
    enter     = 1'b0;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    do_sample = 1'b0;
    do_abort  = 1'b0;
    case (state)
      IDLE: begin
        enter   = nss_fall;
        do_load = nss_fall & ~cpha_i;
      end
      ACTIVE: begin
        busy_o    = 1'b1;
        do_load   = shift_edge & load_pending;
        do_shift  = shift_edge & ~load_pending;
        do_sample = sample_edge;
        do_abort  = nss_rise & (bit_cnt != '0);
      end
      default: ;
    endcase
  end

  assign spi_miso_en_o = busy_o;
  assign tx_ready_o    = ~hold_full;
  assign capture       = tx_valid_i & ~hold_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      if (capture) hold_data <= tx_data_i;
      hold_full <= capture | (hold_full & ~do_load);
    end
  end

  // A load replaces the shift on that edge; pending is re-armed at each word boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_tx     <= '0;
      shift_rx     <= '0;
      bit_cnt      <= '0;
      load_pending <= 1'b0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      spi_miso_o   <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      spi_miso_o <= busy_o & tx_bit;

      if (do_load)       shift_tx <= hold_full ? hold_data : '0;
      else if (do_shift) shift_tx <= tx_shifted;

      if (enter) begin
        bit_cnt      <= '0;
        load_pending <= cpha_i;
      end else if (busy_o && nss_rise) begin
        bit_cnt <= '0;
      end else begin
        if (do_load) load_pending <= 1'b0;
        if (do_sample) begin
          shift_rx <= rx_next;
          if (last_bit) begin
            rx_data_o    <= rx_next;
            rx_valid_o   <= 1'b1;
            bit_cnt      <= '0;
            load_pending <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      udr_o   <= 1'b0;
      abort_o <= 1'b0;
    end else begin
      if (do_load && !hold_full) udr_o <= 1'b1;
      else if (flag_clr_i)       udr_o <= 1'b0;
      if (do_abort)              abort_o <= 1'b1;
      else if (flag_clr_i)       abort_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: drives an SPI master model in clk_i cycles and checks rx/tx/flags.
module tb_spi_slave_if;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpol, cpha, sck, nss, mosi;
  logic       miso, miso_en;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, udr, abort_f, flag_clr;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rx_q[$];

  spi_slave_if #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .cpol_i(cpol), .cpha_i(cpha),
    .spi_sck_i(sck), .spi_nss_i(nss), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_en_o(miso_en),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .busy_o(busy),
    .udr_o(udr), .abort_o(abort_f), .flag_clr_i(flag_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && rx_valid) rx_q.push_back(rx_data);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] d);
    int t = 0;
    while (!tx_ready && t < 100) begin wait_clk(1); t++; end
    n_cmp++;
    if (tx_ready !== 1'b1) begin n_err++; $display("FAIL push_ready: got %b required 1", tx_ready); end
    tx_data = d; tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    flag_clr = 1'b1; wait_clk(1); flag_clr = 1'b0; wait_clk(1);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p; cpha = h; sck = p; wait_clk(4);
  endtask

  task automatic nss_low();
    nss = 1'b0; wait_clk(H);
  endtask

  task automatic nss_high();
    wait_clk(H); nss = 1'b1; wait_clk(H);
  endtask

  task automatic xfer(input logic [7:0] m_out, input int nbits, output logic [7:0] m_in);
    m_in = '0;
    for (int k = 0; k < nbits; k++) begin
      if (!cpha) begin
        mosi = m_out[7-k]; wait_clk(H);
        m_in[7-k] = miso; sck = ~cpol; wait_clk(H);
        sck = cpol;
      end else begin
        sck = ~cpol; mosi = m_out[7-k]; wait_clk(H);
        m_in[7-k] = miso; sck = cpol; wait_clk(H);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cpol = 0; cpha = 0; sck = 0; nss = 1; mosi = 0;
    tx_data = '0; tx_valid = 0; flag_clr = 0;
    wait_clk(3);
    rst = 1'b0; wait_clk(2);
    n_cmp++; if (miso !== 1'b0)    begin n_err++; $display("FAIL rst_miso: got %b required 0", miso); end
    n_cmp++; if (miso_en !== 1'b0) begin n_err++; $display("FAIL rst_miso_en: got %b required 0", miso_en); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_tx_ready: got %b required 1", tx_ready); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rst_rx_data: got %h required 00", rx_data); end
    n_cmp++; if ({rx_valid, busy, udr, abort_f} !== 4'b0) begin n_err++; $display("FAIL rst_flags: got %b required 0000", {rx_valid, busy, udr, abort_f}); end
  endtask

  task automatic test_mode0();
    logic [7:0] m;
    rx_q.delete();
    push_tx(8'hA5);
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL m0_ready_full: got %b required 0", tx_ready); end
    set_mode(0, 0);
    nss_low();
    n_cmp++; if (busy !== 1'b1 || miso_en !== 1'b1) begin n_err++; $display("FAIL m0_busy: got %b%b required 11", busy, miso_en); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL m0_ready_load: got %b required 1", tx_ready); end
    xfer(8'h3C, 8, m);
    nss_high();
    n_cmp++; if (m !== 8'hA5) begin n_err++; $display("FAIL m0_miso: got %h required a5", m); end
    n_cmp++; if (rx_q.size() != 1) begin n_err++; $display("FAIL m0_rx_pulses: got %0d required 1", rx_q.size()); end
    n_cmp++; if (rx_data !== 8'h3C) begin n_err++; $display("FAIL m0_rx_data: got %h required 3c", rx_data); end
    n_cmp++; if (busy !== 1'b0 || miso !== 1'b0) begin n_err++; $display("FAIL m0_idle: got busy %b miso %b required 0 0", busy, miso); end
    pulse_clr();
  endtask

  task automatic test_modes();
    logic [7:0] m;
    for (int md = 1; md <= 3; md++) begin
      rx_q.delete();
      push_tx(8'h7E);
      set_mode(md[1], md[0]);
      nss_low();
      // with cpha=0 the trailing edge after the final bit reloads; keep holding fed
      if (!cpha) push_tx(8'h00);
      xfer(8'h81, 8, m);
      nss_high();
      n_cmp++; if (m !== 8'h7E) begin n_err++; $display("FAIL mode%0d_miso: got %h required 7e", md, m); end
      n_cmp++; if (rx_q.size() != 1 || rx_data !== 8'h81) begin n_err++; $display("FAIL mode%0d_rx: got %0d words data %h required 1 word 81", md, rx_q.size(), rx_data); end
      n_cmp++; if ({udr, abort_f} !== 2'b00) begin n_err++; $display("FAIL mode%0d_flags: got %b required 00", md, {udr, abort_f}); end
      n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL mode%0d_ready: got %b required 1", md, tx_ready); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2;
    rx_q.delete();
    push_tx(8'h55);
    set_mode(0, 1);
    nss_low();
    xfer(8'h12, 8, m1);
    push_tx(8'hAA);
    xfer(8'h34, 8, m2);
    nss_high();
    n_cmp++; if (rx_q.size() != 2) begin n_err++; $display("FAIL b2b_pulses: got %0d required 2", rx_q.size()); end
    else begin
      n_cmp++; if (rx_q[0] !== 8'h12 || rx_q[1] !== 8'h34) begin n_err++; $display("FAIL b2b_rx: got %h %h required 12 34", rx_q[0], rx_q[1]); end
    end
    n_cmp++; if (m1 !== 8'h55 || m2 !== 8'hAA) begin n_err++; $display("FAIL b2b_miso: got %h %h required 55 aa", m1, m2); end
    n_cmp++; if (udr !== 1'b0) begin n_err++; $display("FAIL b2b_udr: got %b required 0", udr); end
  endtask

  task automatic test_underrun();
    logic [7:0] m1, m2;
    rx_q.delete();
    push_tx(8'h66);
    set_mode(0, 1);
    nss_low();
    xfer(8'h0F, 8, m1);
    xfer(8'hF0, 8, m2);
    nss_high();
    n_cmp++; if (m1 !== 8'h66 || m2 !== 8'h00) begin n_err++; $display("FAIL udr_miso: got %h %h required 66 00", m1, m2); end
    n_cmp++; if (rx_q.size() != 2 || rx_data !== 8'hF0) begin n_err++; $display("FAIL udr_rx: got %0d words data %h required 2 words f0", rx_q.size(), rx_data); end
    n_cmp++; if (udr !== 1'b1) begin n_err++; $display("FAIL udr_set: got %b required 1", udr); end
    pulse_clr();
    n_cmp++; if (udr !== 1'b0) begin n_err++; $display("FAIL udr_clear: got %b required 0", udr); end
  endtask

  task automatic test_abort();
    logic [7:0] m;
    rx_q.delete();
    set_mode(0, 1);
    nss_low();
    xfer(8'hFF, 5, m);
    nss_high();
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL abort_no_rx: got %0d pulses required 0", rx_q.size()); end
    n_cmp++; if (abort_f !== 1'b1) begin n_err++; $display("FAIL abort_set: got %b required 1", abort_f); end
    pulse_clr();
    n_cmp++; if ({abort_f, udr} !== 2'b00) begin n_err++; $display("FAIL abort_clear: got %b required 00", {abort_f, udr}); end
    push_tx(8'h3C);
    nss_low();
    xfer(8'hF0, 8, m);
    nss_high();
    n_cmp++; if (rx_q.size() != 1 || rx_data !== 8'hF0) begin n_err++; $display("FAIL abort_next_rx: got %0d words data %h required 1 word f0", rx_q.size(), rx_data); end
    n_cmp++; if (m !== 8'h3C || abort_f !== 1'b0) begin n_err++; $display("FAIL abort_next_miso: got %h abort %b required 3c 0", m, abort_f); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] m;
    rx_q.delete();
    push_tx(8'h5A);
    set_mode(0, 1);
    nss_low();
    xfer(8'hFF, 3, m);
    rst = 1'b1; wait_clk(2);
    n_cmp++; if ({miso, miso_en, rx_valid, busy, udr, abort_f} !== 6'b0) begin n_err++; $display("FAIL mid_rst_outs: got %b required 000000", {miso, miso_en, rx_valid, busy, udr, abort_f}); end
    n_cmp++; if (tx_ready !== 1'b1 || rx_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_data: got ready %b rx %h required 1 00", tx_ready, rx_data); end
    rst = 1'b0; wait_clk(4);
    nss = 1'b1; wait_clk(H);
    n_cmp++; if ({abort_f, udr} !== 2'b00) begin n_err++; $display("FAIL mid_rst_flags: got %b required 00", {abort_f, udr}); end
    rx_q.delete();
    push_tx(8'hC3);
    nss_low();
    xfer(8'h99, 8, m);
    nss_high();
    n_cmp++; if (rx_q.size() != 1 || rx_data !== 8'h99) begin n_err++; $display("FAIL mid_next_rx: got %0d words data %h required 1 word 99", rx_q.size(), rx_data); end
    n_cmp++; if (m !== 8'hC3) begin n_err++; $display("FAIL mid_next_miso: got %h required c3", m); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
